lim_dec_timer: RTL and testbench
================================

# lim_dec_timer

Two-digit limited-decrement countdown timer: the counting-down counterpart of the team's limited incrementor. Each digit counts down modulo its own limit, and a borrow out of the units digit decrements the tens digit. Default limits give a 00–59 count: units modulo 10, tens modulo 6. It sits between the board's tick generator (one-cycle enable pulses, e.g. 1 Hz) and the 7-segment display driver, and it raises a one-cycle `done` pulse when the count expires.

## Interface
Parameters:
- `N`, 4, width of each digit register.
- `L0`, 10, units modulus; legal units values are 0..L0-1; requires 2 ≤ L0 ≤ 2^N.
- `L1`, 6, tens modulus; legal tens values are 0..L1-1; requires 2 ≤ L1 ≤ 2^N.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `load`  in  1  loads preset values into the count; honoured in IDLE only.
- `load_units`  in  N  units preset.
- `load_tens`  in  N  tens preset.
- `start`  in  1  begins the countdown; honoured in IDLE only.
- `tick`  in  1  one-cycle decrement enable; honoured in RUN only.
- `units`  out  N  current units digit (registered).
- `tens`  out  N  current tens digit (registered).
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse on expiry.

## Operation
- The FSM has three states: IDLE, RUN and DONE. All outputs are registered.
- Reset has top priority in every state and at any point mid-count. It forces IDLE, `units`=0, `tens`=0, `busy`=0 and `done`=0.
- Loading in IDLE:
  - A `load` pulse writes the presets to the count.
  - Each preset is clamped to its limit: `units` ← min(`load_units`, L0-1) and `tens` ← min(`load_tens`, L1-1).
  - If `load` and `start` arrive in the same cycle, `load` wins and `start` is ignored.
- Starting from IDLE (with `load`=0):
  - `start` with a nonzero count moves the FSM to RUN.
  - `start` with count 00 moves the FSM directly to DONE.
  - `tick` is ignored in IDLE.
- Counting in RUN, on each `tick`:
  - If `units`>0: `units` decrements by 1.
  - Otherwise (limited decrement with borrow): `units` ← L0-1 and `tens` decrements by 1.
  - If the pre-decrement count is 01 (`tens`=0, `units`=1), the result is 00 and the next state is DONE.
  - A tens borrow from `tens`=0 cannot happen, because RUN exits at 00.
  - `load` and `start` are ignored in RUN; there is no restart mid-count.
- DONE lasts exactly one cycle with `done`=1, then returns to IDLE. The count holds at 00. All inputs except `reset` are ignored in DONE.
- Width rules:
  - All arithmetic is N-bit, with no wrap past 0 other than the modulo reload to L0-1.
  - Comparisons against L0-1 and L1-1 are unsigned.

## Timing
- A `tick` sampled at edge k produces the updated digits at edge k+1 (one-cycle latency).
- The decisive tick (count 01) is sampled at edge k. At edge k+1 the count is 00, the state is DONE, `busy`=0 and `done`=1. At edge k+2 the state is IDLE and `done`=0.
- `start` sampled at edge k in IDLE:
  - Nonzero count: `busy`=1 from edge k+1. A `tick` in that same cycle k is not counted.
  - Count 00: `done`=1 at edge k+1, with `busy` staying 0.
- `load` sampled at edge k in IDLE: the new digits appear at edge k+1.
- Back-to-back ticks (`tick` held high) decrement once per cycle.
- `done` never exceeds one cycle. `busy` and `done` are never high together.

## Test plan
- **Reset values.** Assert `reset` for 2 cycles after random activity → `units`=0, `tens`=0, `busy`=0, `done`=0, and the next `tick` produces no change.
- **Full countdown.** Load 2/5 (count 25), pulse `start`, then give 25 ticks spaced 3 cycles apart. Required response:
  - The count goes 24…20, 19 (borrow: units 0→9, tens 2→1), …, 00.
  - `busy`=1 throughout the run.
  - `done`=1 exactly one cycle after the 25th tick, then IDLE.
- **Clamping.** Load `load_tens`=9, `load_units`=15 → `tens`=5, `units`=9. Start and give 1 tick → 58.
- **Start at zero.** After reset, pulse `start` with count 00 → `done`=1 on the next cycle, `busy` never asserts, and IDLE follows.
- **Ignored inputs during RUN.** Start from 10 and give 1 tick (→ 09). Then:
  - `load` 5/5 plus `start` during RUN → no effect; the count stays 09.
  - Assert `load` and `start` together in IDLE → the load is applied and `start` is ignored (`busy` stays 0).
- **Reset mid-count.** Start from 30, give 4 ticks (→ 26), assert `reset` coincident with a `tick` → 00, IDLE, `done` never pulses.

Source files
------------

// File: rtl/lim_dec_timer_if.sv
// Bus bundle for lim_dec_timer: control and preset inputs, and the registered count and status outputs.
interface lim_dec_timer_if #(
  parameter int N = 4
) ();
  logic         load;
  logic [N-1:0] load_units;
  logic [N-1:0] load_tens;
  logic         start;
  logic         tick;
  logic [N-1:0] units;
  logic [N-1:0] tens;
  logic         busy;
  logic         done;

  modport master (
    output load, load_units, load_tens, start, tick,
    input  units, tens, busy, done
  );

  modport slave (
    input  load, load_units, load_tens, start, tick,
    output units, tens, busy, done
  );
endinterface

// File: rtl/lim_dec_timer.sv
// Two-digit countdown timer. Each digit counts down modulo its own limit, with a borrow from units into tens.
// Loads and starts are accepted in IDLE, ticks in RUN, and expiry gives a one-cycle done pulse.
module lim_dec_timer #(
  parameter int N  = 4,
  parameter int L0 = 10,
  parameter int L1 = 6
) (
  input  logic           clk,
  input  logic           reset,
  lim_dec_timer_if.slave bus
);

  localparam logic [N-1:0] C_U_MAX = N'(L0 - 1);
  localparam logic [N-1:0] C_T_MAX = N'(L1 - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       r_state;
  logic [N-1:0] r_units;
  logic [N-1:0] r_tens;
  logic         r_busy;
  logic         r_done;

  logic [N-1:0] w_units_clamp;
  logic [N-1:0] w_tens_clamp;
  logic         w_count_zero;
  logic         w_last_tick;

  // A preset above a digit's limit is saturated to the largest legal digit.
  assign w_units_clamp = (bus.load_units > C_U_MAX) ? C_U_MAX : bus.load_units;
  assign w_tens_clamp  = (bus.load_tens  > C_T_MAX) ? C_T_MAX : bus.load_tens;
  assign w_count_zero  = (r_units == '0) && (r_tens == '0);
  assign w_last_tick   = (r_units == N'(1)) && (r_tens == '0);

  // NOTE: every register here is assigned with <= so that all of them sample the pre-edge values;
  // a blocking assignment would let the later comparisons see the updated digits within the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_units <= '0;
      r_tens  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.load) begin
            r_units <= w_units_clamp;
            r_tens  <= w_tens_clamp;
          end else if (bus.start) begin
            if (w_count_zero) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (bus.tick) begin
            if (r_units != '0) begin
              r_units <= r_units - 1'b1;
            end else begin
              r_units <= C_U_MAX;
              r_tens  <= r_tens - 1'b1;
            end
            if (w_last_tick) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.units = r_units;
  assign bus.tens  = r_tens;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;

endmodule

// File: tb/tb_lim_dec_timer.sv
// Self-checking bench for lim_dec_timer. It applies directed vectors, multi-cycle sequences and random stimulus,
// and compares the DUT with an arithmetic model that holds the count as a single integer.
module tb_lim_dec_timer;

  localparam int N  = 4;
  localparam int L0 = 10;
  localparam int L1 = 6;

  logic clk;
  logic reset;

  lim_dec_timer_if #(.N(N)) bus ();

  lim_dec_timer #(.N(N), .L0(L0), .L1(L1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Model: phase 0 = idle, 1 = run, 2 = done; the digits are derived from one integer count.
  int m_phase;
  int m_u;
  int m_t;

  typedef struct {
    logic       rst;
    logic       ld;
    logic [3:0] lu;
    logic [3:0] lt;
    logic       st;
    logic       tk;
    logic [3:0] eu;
    logic [3:0] et;
    logic       eb;
    logic       ed;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic ld, input int lu, input int lt,
                       input logic st, input logic tk);
    reset          = r;
    bus.load       = ld;
    bus.load_units = 4'(lu);
    bus.load_tens  = 4'(lt);
    bus.start      = st;
    bus.tick       = tk;
  endtask

  task automatic model_step();
    int c;
    if (reset) begin
      m_phase = 0;
      m_u     = 0;
      m_t     = 0;
    end else begin
      case (m_phase)
        0: begin
          if (bus.load) begin
            m_u = (int'(bus.load_units) < L0 - 1) ? int'(bus.load_units) : L0 - 1;
            m_t = (int'(bus.load_tens)  < L1 - 1) ? int'(bus.load_tens)  : L1 - 1;
          end else if (bus.start) begin
            m_phase = (m_t * L0 + m_u == 0) ? 2 : 1;
          end
        end
        1: begin
          if (bus.tick) begin
            c   = m_t * L0 + m_u - 1;
            m_u = c % L0;
            m_t = c / L0;
            if (c == 0) m_phase = 2;
          end
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("units", 8'(bus.units), 8'(m_u));
    check("tens",  8'(bus.tens),  8'(m_t));
    check("busy",  8'(bus.busy),  8'(m_phase == 1));
    check("done",  8'(bus.done),  8'(m_phase == 2));
    check("busy_and_done", 8'(bus.busy & bus.done), 8'd0);
  endtask

  task automatic idle_cycles(input int n);
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    m_phase = 0;
    m_u     = 0;
    m_t     = 0;
    drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);

    //             rst   ld   lu  lt   st    tk    eu  et  eb    ed
    tbl[0]  = '{1'b1, 1'b0, 0,  0,  1'b0, 1'b0, 0,  0,  1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 15, 9,  1'b0, 1'b0, 9,  5,  1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 0,  0,  1'b1, 1'b1, 9,  5,  1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 0,  0,  1'b0, 1'b1, 8,  5,  1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 5,  5,  1'b1, 1'b1, 7,  5,  1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 0,  0,  1'b0, 1'b0, 7,  5,  1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 0,  0,  1'b0, 1'b1, 0,  0,  1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 0,  0,  1'b0, 1'b1, 0,  0,  1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 0,  0,  1'b1, 1'b0, 0,  0,  1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 3,  3,  1'b1, 1'b1, 0,  0,  1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1,  0,  1'b1, 1'b0, 1,  0,  1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 0,  0,  1'b1, 1'b0, 1,  0,  1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 0,  0,  1'b0, 1'b1, 0,  0,  1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 0,  0,  1'b0, 1'b1, 0,  0,  1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rst, tbl[i].ld, int'(tbl[i].lu), int'(tbl[i].lt), tbl[i].st, tbl[i].tk);
      cycle();
      check($sformatf("tbl%0d_units", i), 8'(bus.units), 8'(tbl[i].eu));
      check($sformatf("tbl%0d_tens",  i), 8'(bus.tens),  8'(tbl[i].et));
      check($sformatf("tbl%0d_busy",  i), 8'(bus.busy),  8'(tbl[i].eb));
      check($sformatf("tbl%0d_done",  i), 8'(bus.done),  8'(tbl[i].ed));
    end

    // Full countdown from 25 with ticks spaced three cycles apart.
    drive(1'b0, 1'b1, 5, 2, 1'b0, 1'b0); cycle();
    drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b0); cycle();
    check("cd_busy_start", 8'(bus.busy), 8'd1);
    for (int k = 1; k <= 25; k++) begin
      drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b1); cycle();
      check("cd_count", 8'(bus.tens) * 8'd10 + 8'(bus.units), 8'(25 - k));
      if (k == 25) begin
        check("cd_done_last", 8'(bus.done), 8'd1);
        check("cd_busy_last", 8'(bus.busy), 8'd0);
      end else begin
        check("cd_busy_mid", 8'(bus.busy), 8'd1);
      end
      idle_cycles(2);
      if (k == 25) check("cd_done_drop", 8'(bus.done), 8'd0);
    end

    // Ignored inputs during RUN, then load+start together in IDLE.
    drive(1'b0, 1'b1, 0, 1, 1'b0, 1'b0); cycle();
    drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b0); cycle();
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b1); cycle();
    check("ign_09", 8'(bus.units), 8'd9);
    drive(1'b0, 1'b1, 5, 5, 1'b1, 1'b0); cycle(); cycle();
    check("ign_hold_u", 8'(bus.units), 8'd9);
    check("ign_hold_t", 8'(bus.tens), 8'd0);
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    for (int k = 0; k < 9; k++) cycle();
    check("ign_done", 8'(bus.done), 8'd1);
    idle_cycles(1);
    drive(1'b0, 1'b1, 4, 3, 1'b1, 1'b0); cycle();
    check("ldst_busy", 8'(bus.busy), 8'd0);
    check("ldst_units", 8'(bus.units), 8'd4);

    // Reset coincident with a tick in the middle of a count.
    drive(1'b0, 1'b1, 0, 3, 1'b0, 1'b0); cycle();
    drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b0); cycle();
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) cycle();
    check("mid_26", 8'(bus.tens) * 8'd10 + 8'(bus.units), 8'd26);
    drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b1); cycle();
    check("mid_rst_u", 8'(bus.units), 8'd0);
    check("mid_rst_b", 8'(bus.busy), 8'd0);
    idle_cycles(2);
    check("mid_no_done", 8'(bus.done), 8'd0);

    // Random stimulus against the model.
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom_range(63) == 0), ($urandom_range(15) == 0),
            int'($urandom_range(15)), int'($urandom_range(15)),
            ($urandom_range(7) == 0), ($urandom_range(2) != 0));
      cycle();
    end

    // Reset for two cycles after random activity; a following tick must not move the count.
    drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b1); cycle(); cycle();
    check("rst_units", 8'(bus.units), 8'd0);
    check("rst_tens",  8'(bus.tens),  8'd0);
    check("rst_busy",  8'(bus.busy),  8'd0);
    check("rst_done",  8'(bus.done),  8'd0);
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b1); cycle();
    check("rst_tick_u", 8'(bus.units), 8'd0);
    check("rst_tick_t", 8'(bus.tens),  8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
